// File: rtl/mem_pkg.sv
// Shared constants for the data memory controller: access sizes, fault codes,
// controller state encoding and a helper returning the byte span of an access.
package mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    localparam logic [1:0] FLT_NONE     = 2'd0;
    localparam logic [1:0] FLT_MISALIGN = 2'd1;
    localparam logic [1:0] FLT_RANGE    = 2'd2;
    localparam logic [1:0] FLT_MODE     = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Number of bytes touched by an access, minus one (offset of its last byte)
    function automatic logic [1:0] access_span(input logic [1:0] mode);
        case (mode)
            MEM_HALF: return 2'd1;
            MEM_WORD: return 2'd3;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bank_array.sv
// Byte-lane storage: four 8-bit banks sharing one word index. Lane i holds
// bits [8i+7:8i] of the aligned word; reads are synchronous and only update
// when enabled, so the output holds between reads.
module dmem_bank_array #(
    parameter int WORDS = 4,
    parameter int IW    = 2
) (
    input  logic          clk,
    input  logic [3:0]    i_we,
    input  logic          i_re,
    input  logic [IW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [WORDS];
            logic [7:0] r_q;

            // Per-lane write with its own enable, registered read on request
            always_ff @(posedge clk) begin
                if (i_we[gi]) begin
                    r_mem[i_idx] <= i_wdata[8*gi +: 8];
                end
                if (i_re) begin
                    r_q <= r_mem[i_idx];
                end
            end

            assign o_rdata[8*gi +: 8] = r_q;
        end
    endgenerate

endmodule

// File: rtl/data_memory_ctrl.sv
// Big-endian byte-addressed data memory controller with wait states,
// sub-word extension and fault detection. The commit (write or read capture)
// happens on the edge entering RESP; with LATENCY=1 that is the accept edge.
module data_memory_ctrl
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = 1048576,
    parameter int ADDR_W    = 32,
    parameter int LATENCY   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        mode,
    input  logic              signExt,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writeData,
    output logic              ready,
    output logic              respValid,
    output logic [31:0]       readData,
    output logic              fault,
    output logic [1:0]        faultCode
);

    localparam int WORDS = MEM_BYTES / 4;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CW    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam int EW    = ADDR_W + 1;
    localparam logic [EW-1:0] LIMIT = EW'(MEM_BYTES);

    state_e            r_state, w_state_next;
    logic [CW-1:0]     r_count, w_count_next;
    logic              w_accept, w_commit;
    logic              w_c_we, w_c_sext;
    logic [1:0]        w_c_mode;
    logic [ADDR_W-1:0] w_c_addr;
    logic [31:0]       w_c_wdata;
    logic [EW-1:0]     w_last;
    logic [1:0]        w_flt;
    logic [3:0]        w_lane_we;
    logic [31:0]       w_wdata_rot;
    logic [31:0]       w_bank_q;
    logic              r_fault, r_rd_zero, r_rd_sext;
    logic [1:0]        r_fault_code, r_rd_mode, r_rd_off;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;

    // rst_n gate keeps a request seen during reset from committing
    assign w_accept  = rst_n && req && (r_state != BUSY);
    assign ready     = (r_state != BUSY);
    assign respValid = (r_state == RESP);
    assign fault     = r_fault;
    assign faultCode = r_fault_code;

    generate
        if (LATENCY == 1) begin : g_direct
            // Commit coincides with acceptance, so the live request is used
            assign w_c_we    = we;
            assign w_c_sext  = signExt;
            assign w_c_mode  = mode;
            assign w_c_addr  = address;
            assign w_c_wdata = writeData;
            assign w_commit  = w_accept;
        end else begin : g_staged
            logic              r_we, r_sext;
            logic [1:0]        r_mode;
            logic [ADDR_W-1:0] r_addr;
            logic [31:0]       r_wdata;

            // Hold the accepted request stable through the wait states
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_we    <= 1'b0;
                    r_sext  <= 1'b0;
                    r_mode  <= MEM_BYTE;
                    r_addr  <= '0;
                    r_wdata <= '0;
                end else if (w_accept) begin
                    r_we    <= we;
                    r_sext  <= signExt;
                    r_mode  <= mode;
                    r_addr  <= address;
                    r_wdata <= writeData;
                end
            end

            assign w_c_we    = r_we;
            assign w_c_sext  = r_sext;
            assign w_c_mode  = r_mode;
            assign w_c_addr  = r_addr;
            assign w_c_wdata = r_wdata;
            assign w_commit  = (r_state == BUSY) && (r_count == '0);
        end
    endgenerate

    // State and wait-counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    // Next-state: RESP accepts back-to-back just like IDLE
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        case (r_state)
            IDLE, RESP: begin
                w_state_next = IDLE;
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_next = RESP;
                    end else begin
                        w_state_next = BUSY;
                        w_count_next = CW'(LATENCY - 2);
                    end
                end
            end
            BUSY: begin
                if (r_count == '0) begin
                    w_state_next = RESP;
                end else begin
                    w_count_next = r_count - CW'(1);
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Fault classification; last-byte address is widened so it cannot wrap
    always_comb begin
        w_last = {1'b0, w_c_addr} + EW'(access_span(w_c_mode));
        w_flt  = FLT_NONE;
        if (!(w_c_mode inside {MEM_BYTE, MEM_HALF, MEM_WORD})) begin
            w_flt = FLT_MODE;
        end else if (w_last >= LIMIT) begin
            w_flt = FLT_RANGE;
        end else if ((w_c_mode == MEM_HALF && w_c_addr[0]) ||
                     (w_c_mode == MEM_WORD && w_c_addr[1:0] != 2'b00)) begin
            w_flt = FLT_MISALIGN;
        end
    end

    // Store lane steering: byte offset 0 lives in lane 3 (bits 31:24)
    always_comb begin
        w_lane_we   = 4'b1111;
        w_wdata_rot = w_c_wdata;
        case (w_c_mode)
            MEM_BYTE: begin
                w_wdata_rot = {4{w_c_wdata[7:0]}};
                case (w_c_addr[1:0])
                    2'd0:    w_lane_we = 4'b1000;
                    2'd1:    w_lane_we = 4'b0100;
                    2'd2:    w_lane_we = 4'b0010;
                    default: w_lane_we = 4'b0001;
                endcase
            end
            MEM_HALF: begin
                w_wdata_rot = {2{w_c_wdata[15:0]}};
                w_lane_we   = w_c_addr[1] ? 4'b0011 : 4'b1100;
            end
            default: begin
                w_lane_we   = 4'b1111;
                w_wdata_rot = w_c_wdata;
            end
        endcase
    end

    dmem_bank_array #(
        .WORDS(WORDS),
        .IW   (IW)
    ) u_bank (
        .clk    (clk),
        .i_we   ((w_commit && w_c_we && w_flt == FLT_NONE) ? w_lane_we : 4'b0000),
        .i_re   (w_commit && !w_c_we && w_flt == FLT_NONE),
        .i_idx  (w_c_addr[IW+1:2]),
        .i_wdata(w_wdata_rot),
        .o_rdata(w_bank_q)
    );

    // Response bookkeeping captured at commit; drives fault and load extraction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault      <= 1'b0;
            r_fault_code <= FLT_NONE;
            r_rd_zero    <= 1'b1;
            r_rd_sext    <= 1'b0;
            r_rd_mode    <= MEM_BYTE;
            r_rd_off     <= 2'd0;
        end else if (w_commit) begin
            r_fault      <= (w_flt != FLT_NONE);
            r_fault_code <= w_flt;
            r_rd_zero    <= w_c_we || (w_flt != FLT_NONE);
            r_rd_sext    <= w_c_sext;
            r_rd_mode    <= w_c_mode;
            r_rd_off     <= w_c_addr[1:0];
        end
    end

    // Load extraction and extension from the registered bank word
    always_comb begin
        case (r_rd_off)
            2'd0:    w_byte = w_bank_q[31:24];
            2'd1:    w_byte = w_bank_q[23:16];
            2'd2:    w_byte = w_bank_q[15:8];
            default: w_byte = w_bank_q[7:0];
        endcase
        w_half   = r_rd_off[1] ? w_bank_q[15:0] : w_bank_q[31:16];
        readData = '0;
        if (!r_rd_zero) begin
            case (r_rd_mode)
                MEM_BYTE: readData = {{24{r_rd_sext & w_byte[7]}}, w_byte};
                MEM_HALF: readData = {{16{r_rd_sext & w_half[15]}}, w_half};
                default:  readData = w_bank_q;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: three controller instances (LATENCY 1/4/3) share the
// request buses; each has its own req and reset. Expected values are
// hand-derived from the big-endian layout and extension rules.
module tb_data_memory_ctrl;

    localparam logic [1:0] MB = 2'd0;
    localparam logic [1:0] MH = 2'd1;
    localparam logic [1:0] MW = 2'd2;
    localparam logic [1:0] MX = 2'd3;

    logic        clk = 1'b0;
    logic [2:0]  req_v  = 3'b000;
    logic [2:0]  rstn_v = 3'b000;
    logic        we_s   = 1'b0;
    logic [1:0]  mode_s = 2'd0;
    logic        sext_s = 1'b0;
    logic [31:0] addr_s = '0;
    logic [31:0] wdata_s = '0;

    wire  [2:0]  ready_v, resp_v, fault_v;
    wire  [31:0] rd_v [3];
    wire  [1:0]  fc_v [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_memory_ctrl #(.MEM_BYTES(1024), .ADDR_W(32), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst_n(rstn_v[0]), .req(req_v[0]), .we(we_s), .mode(mode_s),
        .signExt(sext_s), .address(addr_s), .writeData(wdata_s),
        .ready(ready_v[0]), .respValid(resp_v[0]), .readData(rd_v[0]),
        .fault(fault_v[0]), .faultCode(fc_v[0])
    );

    data_memory_ctrl #(.MEM_BYTES(1048576), .ADDR_W(32), .LATENCY(4)) u_lat4 (
        .clk(clk), .rst_n(rstn_v[1]), .req(req_v[1]), .we(we_s), .mode(mode_s),
        .signExt(sext_s), .address(addr_s), .writeData(wdata_s),
        .ready(ready_v[1]), .respValid(resp_v[1]), .readData(rd_v[1]),
        .fault(fault_v[1]), .faultCode(fc_v[1])
    );

    data_memory_ctrl #(.MEM_BYTES(1024), .ADDR_W(32), .LATENCY(3)) u_lat3 (
        .clk(clk), .rst_n(rstn_v[2]), .req(req_v[2]), .we(we_s), .mode(mode_s),
        .signExt(sext_s), .address(addr_s), .writeData(wdata_s),
        .ready(ready_v[2]), .respValid(resp_v[2]), .readData(rd_v[2]),
        .fault(fault_v[2]), .faultCode(fc_v[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [1:0] m, input logic s,
                         input logic [31:0] a, input logic [31:0] d);
        we_s = w; mode_s = m; sext_s = s; addr_s = a; wdata_s = d;
    endtask

    // One request on instance sel, called just after a falling edge; waits
    // (bounded) for the response and checks latency and response fields.
    task automatic xact(input int sel, input int lat, input string tag,
                        input logic w, input logic [1:0] m, input logic s,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_f,
                        input logic [1:0] exp_fc);
        int cyc;
        drive(w, m, s, a, d);
        check({tag, ".ready"}, 32'(ready_v[sel]), 32'd1);
        req_v[sel] = 1'b1;
        @(negedge clk);
        req_v[sel] = 1'b0;
        cyc = 1;
        while (resp_v[sel] !== 1'b1 && cyc < 16) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, ".latency"}, 32'(cyc), 32'(lat));
        check({tag, ".readData"}, rd_v[sel], exp_rd);
        check({tag, ".fault"}, 32'(fault_v[sel]), 32'(exp_f));
        check({tag, ".faultCode"}, 32'(fc_v[sel]), 32'(exp_fc));
        $display("xact %-14s inst=%0d we=%0d mode=%0d addr=0x%08h rd=0x%08h fault=%0d code=%0d lat=%0d",
                 tag, sel, w, m, a, rd_v[sel], fault_v[sel], fc_v[sel], cyc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values on all instances
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset%0d.ready", i), 32'(ready_v[i]), 32'd1);
            check($sformatf("reset%0d.respValid", i), 32'(resp_v[i]), 32'd0);
            check($sformatf("reset%0d.readData", i), rd_v[i], 32'd0);
            check($sformatf("reset%0d.fault", i), 32'(fault_v[i]), 32'd0);
            check($sformatf("reset%0d.faultCode", i), 32'(fc_v[i]), 32'd0);
        end
        rstn_v = 3'b111;
        @(negedge clk);

        // LATENCY=1: word store/load, big-endian byte and half reads
        xact(0, 1, "st_w_10",   1, MW, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2'd0);
        xact(0, 1, "ld_w_10",   0, MW, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2'd0);
        xact(0, 1, "ld_b_10",   0, MB, 0, 32'h10, 32'h0,        32'h000000DE, 0, 2'd0);
        xact(0, 1, "ld_bs_13",  0, MB, 1, 32'h13, 32'h0,        32'hFFFFFFEF, 0, 2'd0);
        xact(0, 1, "ld_h_12",   0, MH, 0, 32'h12, 32'h0,        32'h0000BEEF, 0, 2'd0);
        @(negedge clk);
        check("idle_after.respValid", 32'(resp_v[0]), 32'd0);

        // Sub-word stores and extension
        xact(0, 1, "st_b_21",   1, MB, 0, 32'h21, 32'h12345680, 32'h0,        0, 2'd0);
        xact(0, 1, "ld_bs_21",  0, MB, 1, 32'h21, 32'h0,        32'hFFFFFF80, 0, 2'd0);
        xact(0, 1, "ld_bz_21",  0, MB, 0, 32'h21, 32'h0,        32'h00000080, 0, 2'd0);
        xact(0, 1, "st_b_20",   1, MB, 0, 32'h20, 32'h000000FF, 32'h0,        0, 2'd0);
        xact(0, 1, "ld_hs_20",  0, MH, 1, 32'h20, 32'h0,        32'hFFFFFF80, 0, 2'd0);
        xact(0, 1, "ld_hz_20",  0, MH, 0, 32'h20, 32'h0,        32'h0000FF80, 0, 2'd0);

        // Misalignment faults leave memory untouched
        xact(0, 1, "st_w_30",   1, MW, 0, 32'h30, 32'h11223344, 32'h0,        0, 2'd0);
        xact(0, 1, "ld_w_02",   0, MW, 0, 32'h02, 32'h0,        32'h0,        1, 2'd1);
        xact(0, 1, "st_h_33",   1, MH, 0, 32'h33, 32'h0000AAAA, 32'h0,        1, 2'd1);
        xact(0, 1, "ld_w_30",   0, MW, 0, 32'h30, 32'h0,        32'h11223344, 0, 2'd0);
        xact(0, 1, "st_h_32",   1, MH, 0, 32'h32, 32'h0000BEEF, 32'h0,        0, 2'd0);
        xact(0, 1, "ld_w_30b",  0, MW, 0, 32'h30, 32'h0,        32'h1122BEEF, 0, 2'd0);

        // Range and mode faults, with priority, at the 1 KiB boundary
        xact(0, 1, "ld_w_3fe",  0, MW, 0, 32'h3FE, 32'h0,       32'h0,        1, 2'd2);
        xact(0, 1, "ill_3fe",   0, MX, 0, 32'h3FE, 32'h0,       32'h0,        1, 2'd3);
        xact(0, 1, "ill_10",    0, MX, 0, 32'h10,  32'h0,       32'h0,        1, 2'd3);
        xact(0, 1, "ld_h_3ff",  0, MH, 0, 32'h3FF, 32'h0,       32'h0,        1, 2'd2);
        xact(0, 1, "st_b_3ff",  1, MB, 0, 32'h3FF, 32'h0000005A, 32'h0,       0, 2'd0);
        xact(0, 1, "ld_b_3ff",  0, MB, 0, 32'h3FF, 32'h0,       32'h0000005A, 0, 2'd0);
        xact(0, 1, "ld_b_400",  0, MB, 0, 32'h400, 32'h0,       32'h0,        1, 2'd2);
        xact(0, 1, "ld_b_wrap", 0, MB, 0, 32'hFFFFFFFF, 32'h0,  32'h0,        1, 2'd2);

        // LATENCY=4 back-to-back with req held high
        drive(1, MW, 0, 32'h100, 32'hCAFEF00D);
        check("l4.ready0", 32'(ready_v[1]), 32'd1);
        req_v[1] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check($sformatf("l4.c%0d.respValid", i), 32'(resp_v[1]), 32'((i == 4) || (i == 8)));
            check($sformatf("l4.c%0d.ready", i), 32'(ready_v[1]), 32'((i == 4) || (i == 8)));
            if (i == 1) drive(0, MW, 0, 32'h100, 32'h0);
            if (i == 4) check("l4.store.readData", rd_v[1], 32'h0);
            if (i == 5) req_v[1] = 1'b0;
            if (i == 8) begin
                check("l4.load.readData", rd_v[1], 32'hCAFEF00D);
                check("l4.load.fault", 32'(fault_v[1]), 32'd0);
            end
            $display("l4 cycle %0d ready=%0d respValid=%0d rd=0x%08h", i, ready_v[1], resp_v[1], rd_v[1]);
        end
        @(negedge clk);
        check("l4.idle.respValid", 32'(resp_v[1]), 32'd0);

        // LATENCY=3: reset during BUSY cancels an uncommitted store
        xact(2, 3, "l3_st_init", 1, MW, 0, 32'h40, 32'hA5A5A5A5, 32'h0, 0, 2'd0);
        drive(1, MW, 0, 32'h40, 32'h12345678);
        req_v[2] = 1'b1;
        @(negedge clk);
        req_v[2] = 1'b0;
        check("l3.busy1.ready", 32'(ready_v[2]), 32'd0);
        @(negedge clk);
        check("l3.busy2.ready", 32'(ready_v[2]), 32'd0);
        check("l3.busy2.respValid", 32'(resp_v[2]), 32'd0);
        rstn_v[2] = 1'b0;
        #1;
        check("l3.rst.ready", 32'(ready_v[2]), 32'd1);
        check("l3.rst.respValid", 32'(resp_v[2]), 32'd0);
        check("l3.rst.readData", rd_v[2], 32'd0);
        $display("l3 reset asserted mid-BUSY ready=%0d respValid=%0d", ready_v[2], resp_v[2]);
        @(negedge clk);
        rstn_v[2] = 1'b1;
        @(negedge clk);
        xact(2, 3, "l3_ld_after", 0, MW, 0, 32'h40, 32'h0, 32'hA5A5A5A5, 0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
